// File: rtl/core_lsu.sv
// Load/store unit: one data-bus transaction per accepted load/store, with byte lanes and extension.
// Optional LSU_MISALIGN_TRAP_EN: misaligned halfword/word accesses complete with o_err, no bus cycle.
`timescale 1ns/1ps
module core_lsu (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic [6:0]  i_opcode,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [31:0] o_rdata,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [3:0]  o_bus_be,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_gnt,
    input  logic        i_bus_rvalid,
    input  logic [31:0] i_bus_rdata
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StReq  = 2'd1;
    localparam logic [1:0] StWait = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;

    logic [1:0]  state_q, state_d;
    logic        err_q, err_d;
    logic        is_load_q, is_load_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  lane_q, lane_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] rdata_q, rdata_d;

    logic        is_ld, is_st, f3_legal, misalign;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] rd_ext;

    assign is_ld = (i_opcode == OpLoad);
    assign is_st = (i_opcode == OpStore);

    always_comb begin
        case (i_funct3)
            3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
            3'b100, 3'b101:         f3_legal = is_ld;
            default:                f3_legal = 1'b0;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    always_comb begin
        case (i_funct3[1:0])
            2'b01:   misalign = i_addr[0];
            2'b10:   misalign = |i_addr[1:0];
            default: misalign = 1'b0;
        endcase
    end
`else
    assign misalign = 1'b0;
`endif

    // Lane selection ignores address bits below the access size.
    always_comb begin
        case (i_funct3[1:0])
            2'b00: begin
                be_new    = 4'b0001 << i_addr[1:0];
                wdata_new = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                be_new    = i_addr[1] ? 4'b1100 : 4'b0011;
                wdata_new = {2{i_wdata[15:0]}};
            end
            default: begin
                be_new    = 4'b1111;
                wdata_new = i_wdata;
            end
        endcase
    end

    always_comb begin
        case (lane_q)
            2'd0:    rd_byte = i_bus_rdata[7:0];
            2'd1:    rd_byte = i_bus_rdata[15:8];
            2'd2:    rd_byte = i_bus_rdata[23:16];
            default: rd_byte = i_bus_rdata[31:24];
        endcase
        rd_half = lane_q[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];
        case (funct3_q)
            3'b000:  rd_ext = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  rd_ext = {{16{rd_half[15]}}, rd_half};
            3'b100:  rd_ext = {24'd0, rd_byte};
            3'b101:  rd_ext = {16'd0, rd_half};
            default: rd_ext = i_bus_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        err_d       = err_q;
        is_load_d   = is_load_q;
        funct3_d    = funct3_q;
        lane_d      = lane_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        bus_we_d    = bus_we_q;
        rdata_d     = rdata_q;
        case (state_q)
            StIdle: begin
                if (i_valid && (is_ld || is_st)) begin
                    is_load_d = is_ld;
                    funct3_d  = i_funct3;
                    lane_d    = i_addr[1:0];
                    err_d     = !f3_legal || misalign;
                    if (!f3_legal || misalign) begin
                        state_d = StDone;
                    end else begin
                        state_d     = StReq;
                        bus_addr_d  = {i_addr[31:2], 2'b00};
                        bus_be_d    = be_new;
                        bus_wdata_d = wdata_new;
                        bus_we_d    = is_st;
                    end
                end
            end
            StReq: begin
                if (i_bus_gnt) begin
                    if (!is_load_q) begin
                        state_d = StDone;
                    end else if (i_bus_rvalid) begin
                        rdata_d = rd_ext;
                        state_d = StDone;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (i_bus_rvalid) begin
                    rdata_d = rd_ext;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= StIdle;
            err_q       <= 1'b0;
            is_load_q   <= 1'b0;
            funct3_q    <= 3'd0;
            lane_q      <= 2'd0;
            bus_addr_q  <= 32'd0;
            bus_be_q    <= 4'd0;
            bus_wdata_q <= 32'd0;
            bus_we_q    <= 1'b0;
            rdata_q     <= 32'd0;
        end else begin
            state_q     <= state_d;
            err_q       <= err_d;
            is_load_q   <= is_load_d;
            funct3_q    <= funct3_d;
            lane_q      <= lane_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            bus_we_q    <= bus_we_d;
            rdata_q     <= rdata_d;
        end
    end

    assign o_busy      = (state_q != StIdle);
    assign o_done      = (state_q == StDone);
    assign o_err       = (state_q == StDone) && err_q;
    assign o_bus_req   = (state_q == StReq);
    assign o_bus_we    = bus_we_q;
    assign o_bus_addr  = bus_addr_q;
    assign o_bus_be    = bus_be_q;
    assign o_bus_wdata = bus_wdata_q;
    assign o_rdata     = rdata_q;

endmodule

// File: tb/tb_core_lsu.sv
// Scoreboard bench for core_lsu: directed scenarios then randomized traffic against a byte-level model.
`timescale 1ns/1ps
module tb_core_lsu;

    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit Trap = 1'b1;
`else
    localparam bit Trap = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, valid;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        busy, done, err;
    logic [31:0] rdata;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        gnt = 1'b0, rvalid = 1'b0;
    logic [31:0] bus_rdata = 32'd0;

    core_lsu dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_valid      (valid),
        .i_opcode     (opcode),
        .i_funct3     (funct3),
        .i_addr       (addr),
        .i_wdata      (wdata),
        .o_busy       (busy),
        .o_done       (done),
        .o_err        (err),
        .o_rdata      (rdata),
        .o_bus_req    (bus_req),
        .o_bus_we     (bus_we),
        .o_bus_addr   (bus_addr),
        .o_bus_be     (bus_be),
        .o_bus_wdata  (bus_wdata),
        .i_bus_gnt    (gnt),
        .i_bus_rvalid (rvalid),
        .i_bus_rdata  (bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    int          n_checks = 0;
    int          n_fail = 0;
    exp_t        sb_q[$];
    logic [31:0] ref_mem[16];
    logic [31:0] bus_mem[16];
    logic [31:0] last_rdata = 32'd0;
    int          gnt_dly = -1;
    int          rv_dly = -1;
    bit          force_en = 1'b0;
    logic [31:0] force_val = 32'd0;

    function automatic logic [31:0] init_word(input int i);
        return 32'(32'h9E3779B9 * (i + 1));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] get_byte(input logic [31:0] a);
        logic [31:0] w;
        w = force_en ? force_val : ref_mem[a[5:2]];
        return w[8*a[1:0] +: 8];
    endfunction

    // Reference: memory is a flat byte array; accesses are size-aligned byte runs.
    task automatic model_issue(input bit ld, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] wd);
        int          nbytes, off;
        bit          legal, bad;
        logic [31:0] base, w;
        longint      val;
        exp_t        e;
        legal  = ld ? (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5)
                    : (f3 <= 3'd2);
        nbytes = 1 << f3[1:0];
        off    = int'(a[1:0]) % nbytes;
        bad    = !legal || (Trap && off != 0);
        if (!bad) begin
            base = a - 32'(off);
            if (ld) begin
                val = 0;
                for (int i = 0; i < nbytes; i++)
                    val = val | (longint'(get_byte(base + 32'(i))) << (8 * i));
                if (!f3[2] && nbytes < 4 && val[8*nbytes-1])
                    val = val - (longint'(1) << (8 * nbytes));
                last_rdata = val[31:0];
            end else begin
                for (int i = 0; i < nbytes; i++) begin
                    w = base + 32'(i);
                    ref_mem[w[5:2]][8*w[1:0] +: 8] = wd[8*i +: 8];
                end
            end
        end
        e.err   = bad;
        e.rdata = last_rdata;
        sb_q.push_back(e);
    endtask

    function automatic logic [31:0] resp(input logic [31:0] a);
        return force_en ? force_val : bus_mem[a[5:2]];
    endfunction

    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd);
        valid  = 1'b1;
        opcode = op;
        funct3 = f3;
        addr   = a;
        wdata  = wd;
        if (op == OP_LD || op == OP_ST) model_issue(op == OP_LD, f3, a, wd);
        @(negedge clk);
        valid  = 1'b0;
        opcode = 7'($urandom);
        funct3 = 3'($urandom);
        addr   = $urandom;
        wdata  = $urandom;
    endtask

    task automatic pulse_valid();
        valid  = 1'b1;
        opcode = ($urandom_range(0, 1) == 0) ? OP_LD : OP_ST;
        funct3 = 3'($urandom_range(0, 2));
        addr   = 32'h1010;
        wdata  = $urandom;
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got no o_done within %0d cycles, required a completion", cyc);
        end
    endtask

    // Bus slave: grants/returns data with configurable or random delay; applies writes to bus_mem.
    initial begin
        bit          req_seen, we_seen, rd_pend;
        logic [31:0] s_addr, s_wdata, pend_addr;
        logic [3:0]  s_be;
        int          req_cnt, rv_cnt;
        req_seen = 0; we_seen = 0; rd_pend = 0;
        s_addr = 0; s_wdata = 0; pend_addr = 0; s_be = 0;
        req_cnt = 0; rv_cnt = 0;
        for (int i = 0; i < 16; i++) bus_mem[i] = init_word(i);
        forever begin
            @(negedge clk);
            if (gnt && req_seen) begin
                if (we_seen) begin
                    for (int b = 0; b < 4; b++)
                        if (s_be[b]) bus_mem[s_addr[5:2]][8*b +: 8] = s_wdata[8*b +: 8];
                end else if (!rvalid) begin
                    rd_pend   = 1'b1;
                    rv_cnt    = 1;
                    pend_addr = s_addr;
                end
            end else if (rvalid) begin
                rd_pend = 1'b0;
            end
            gnt       = 1'b0;
            rvalid    = 1'b0;
            bus_rdata = $urandom;
            if (rd_pend) begin
                if ((rv_dly < 0) ? ($urandom_range(0, 2) == 0) : (rv_cnt >= rv_dly)) begin
                    rvalid    = 1'b1;
                    bus_rdata = resp(pend_addr);
                end else begin
                    rv_cnt++;
                end
            end else if (bus_req) begin
                if ((gnt_dly < 0) ? ($urandom_range(0, 2) == 0) : (req_cnt >= gnt_dly)) begin
                    gnt     = 1'b1;
                    req_cnt = 0;
                    if (!bus_we && ((rv_dly < 0) ? ($urandom_range(0, 1) == 1) : (rv_dly == 0))) begin
                        rvalid    = 1'b1;
                        bus_rdata = resp(bus_addr);
                    end
                end else begin
                    req_cnt++;
                end
            end
            req_seen = bus_req;
            we_seen  = bus_we;
            s_addr   = bus_addr;
            s_be     = bus_be;
            s_wdata  = bus_wdata;
        end
    end

    // Monitor: every completion must match the oldest outstanding expectation.
    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            if (done) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got o_done=1 with nothing outstanding at %0t", $time);
                end else begin
                    e = sb_q.pop_front();
                    chk("done_err", 32'(err), 32'(e.err));
                    chk("done_rdata", rdata, e.rdata);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc;
        logic [6:0]  op;
        int          r;
        rst = 1'b1; valid = 1'b0; opcode = 7'd0; funct3 = 3'd0; addr = 32'd0; wdata = 32'd0;
        for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_req", 32'(bus_req), 32'd0);
        chk("rst_we", 32'(bus_we), 32'd0);
        chk("rst_addr", bus_addr, 32'd0);
        chk("rst_be", 32'(bus_be), 32'd0);
        chk("rst_wdata", bus_wdata, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // LB at 0x1003, immediate gnt, data one cycle later
        gnt_dly = 0; rv_dly = 1; force_en = 1'b1; force_val = 32'h80123456;
        issue(OP_LD, 3'b000, 32'h1003, $urandom);
        chk("lb_req", 32'(bus_req), 32'd1);
        chk("lb_addr", bus_addr, 32'h1000);
        chk("lb_be", 32'(bus_be), 32'h8);
        chk("lb_we", 32'(bus_we), 32'd0);
        wait_done(cyc);
        chk("lb_latency", 32'(cyc), 32'd3);
        chk("lb_rdata", rdata, 32'hFFFFFF80);
        @(negedge clk);
        force_en = 1'b0;

        // SH at 0x2002 with gnt held off three cycles
        gnt_dly = 3;
        issue(OP_ST, 3'b001, 32'h2002, 32'h1234ABCD);
        for (int k = 0; k < 4; k++) begin
            chk("sh_req", 32'(bus_req), 32'd1);
            chk("sh_addr", bus_addr, 32'h2000);
            chk("sh_be", 32'(bus_be), 32'hC);
            chk("sh_wdata", bus_wdata, 32'hABCDABCD);
            chk("sh_we", 32'(bus_we), 32'd1);
            @(negedge clk);
        end
        chk("sh_done", 32'(done), 32'd1);
        chk("sh_rdata_held", rdata, 32'hFFFFFF80);
        @(negedge clk);

        // LHU at 0x3000, gnt and rvalid together
        gnt_dly = 0; rv_dly = 0; force_en = 1'b1; force_val = 32'h0000F00D;
        issue(OP_LD, 3'b101, 32'h3000, $urandom);
        wait_done(cyc);
        chk("lhu_latency", 32'(cyc), 32'd2);
        chk("lhu_rdata", rdata, 32'h0000F00D);
        @(negedge clk);
        force_en = 1'b0;

        // LW at 0x1001
        gnt_dly = 0; rv_dly = 1;
        issue(OP_LD, 3'b010, 32'h1001, $urandom);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("lw_mis_req", 32'(bus_req), 32'd0);
        chk("lw_mis_done", 32'(done), 32'd1);
        chk("lw_mis_err", 32'(err), 32'd1);
        @(negedge clk);
        chk("lw_mis_req2", 32'(bus_req), 32'd0);
`else
        chk("lw_mis_req", 32'(bus_req), 32'd1);
        chk("lw_mis_addr", bus_addr, 32'h1000);
        chk("lw_mis_be", 32'(bus_be), 32'hF);
        wait_done(cyc);
        chk("lw_mis_latency", 32'(cyc), 32'd3);
`endif
        @(negedge clk);

        // Illegal funct3 load
        issue(OP_LD, 3'b011, 32'h1004, $urandom);
        chk("ill_done", 32'(done), 32'd1);
        chk("ill_err", 32'(err), 32'd1);
        chk("ill_req", 32'(bus_req), 32'd0);
        @(negedge clk);

        // Non-memory opcode is ignored
        issue(7'b0110011, 3'b000, 32'h1000, $urandom);
        chk("other_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("other_done", 32'(done), 32'd0);

        // Second valid while busy is ignored
        gnt_dly = 2; rv_dly = 1;
        issue(OP_LD, 3'b010, 32'h1008, $urandom);
        pulse_valid();
        wait_done(cyc);
        @(negedge clk);
        repeat (3) begin
            chk("busy_single_done", 32'(done), 32'd0);
            @(negedge clk);
        end
        gnt_dly = 0; rv_dly = 1;
        issue(OP_LD, 3'b010, 32'h1010, $urandom);
        wait_done(cyc);
        @(negedge clk);

        // Reset in WAIT with a late rvalid
        gnt_dly = 0; rv_dly = 5;
        issue(OP_LD, 3'b010, 32'h1014, $urandom);
        @(negedge clk);
        chk("wait_busy", 32'(busy), 32'd1);
        chk("wait_req", 32'(bus_req), 32'd0);
        #1 rst = 1'b1;
        #1;
        sb_q.delete();
        last_rdata = 32'd0;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_req", 32'(bus_req), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            chk("post_rst_done", 32'(done), 32'd0);
        end
        chk("post_rst_rdata", rdata, 32'd0);
        chk("post_rst_addr", bus_addr, 32'd0);
        gnt_dly = -1; rv_dly = -1;
        issue(OP_LD, 3'b010, 32'h1018, $urandom);
        wait_done(cyc);
        @(negedge clk);

        // Randomized traffic
        repeat (250) begin
            r  = $urandom_range(0, 9);
            op = (r < 5) ? OP_LD : (r < 9) ? OP_ST : 7'b0010011;
            issue(op, 3'($urandom_range(0, 7)), 32'h1000 + $urandom_range(0, 63), $urandom);
            if (op == OP_LD || op == OP_ST) begin
                if ($urandom_range(0, 3) == 0 && busy && !done) pulse_valid();
                wait_done(cyc);
                @(negedge clk);
            end
        end
        repeat (5) @(negedge clk);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
